// File: rtl/bit_serial_adder_if.sv
// Handshake and operand/result bundle between a controller and the bit-serial adder.
// The master drives the request and operands; the slave (adder) returns the result and status.
interface bit_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;
  logic             busy_out;
  logic             done_out;

  modport master (
    output start_in, a_in, b_in, c_in,
    input  sum_out, carry_out, busy_out, done_out
  );

  modport slave (
    input  start_in, a_in, b_in, c_in,
    output sum_out, carry_out, busy_out, done_out
  );
endinterface

// File: rtl/bit_serial_adder.sv
// WIDTH-bit adder that uses a single full-adder slice, one bit per clock, LSB first.
// Operands load on start; the result registers update only when the last bit completes.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  bit_serial_adder_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, b_sh_reg;
  // Partial sum keeps only WIDTH-1 bits: the slot that would shift out is never needed.
  logic [WIDTH-2:0] s_sh_reg;
  logic             cy_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;

  logic             fa_sum, fa_carry;
  logic [WIDTH-1:0] a_shr, b_shr, s_full;

  assign fa_sum   = a_sh_reg[0] ^ b_sh_reg[0] ^ cy_reg;
  assign fa_carry = (a_sh_reg[0] & b_sh_reg[0]) | (cy_reg & (a_sh_reg[0] ^ b_sh_reg[0]));

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign a_shr[gi] = a_sh_reg[gi+1];
      assign b_shr[gi] = b_sh_reg[gi+1];
    end
  endgenerate
  assign a_shr[WIDTH-1] = 1'b0;
  assign b_shr[WIDTH-1] = 1'b0;
  assign s_full         = {fa_sum, s_sh_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start_in) state_next = RUN;
      RUN:     if (cnt_reg == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy_out = (state_reg == RUN);
    bus.done_out = (state_reg == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      s_sh_reg  <= '0;
      cy_reg    <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start_in) begin
            a_sh_reg <= bus.a_in;
            b_sh_reg <= bus.b_in;
            cy_reg   <= bus.c_in;
            cnt_reg  <= '0;
          end
        end
        RUN: begin
          a_sh_reg <= a_shr;
          b_sh_reg <= b_shr;
          s_sh_reg <= s_full[WIDTH-1:1];
          cy_reg   <= fa_carry;
          cnt_reg  <= cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            sum_reg   <= s_full;
            carry_reg <= fa_carry;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sum_out   = sum_reg;
  assign bus.carry_out = carry_reg;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Randomized and directed checks of the bit-serial adder against plain a+b+c arithmetic,
// with handshake timing checked in cycles; a 4-bit instance is swept exhaustively.
module tb_bit_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   done4_cnt = 0;

  always #5 clk = ~clk;

  bit_serial_adder_if #(.WIDTH(8)) bus8 ();
  bit_serial_adder_if #(.WIDTH(4)) bus4 ();

  bit_serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  bit_serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  always @(posedge clk) if (bus4.done_out === 1'b1) done4_cnt++;

  // One complete 8-bit operation: timing, overlap, result stability and final value.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, input string tag);
    logic [8:0] expv;
    logic [7:0] prev_sum;
    logic       prev_carry;
    int         busy_n, lat;
    bit         seen, stable, overlap;
    expv = 9'(a) + 9'(b) + 9'(c);
    @(negedge clk);
    bus8.start_in = 1'b1; bus8.a_in = a; bus8.b_in = b; bus8.c_in = c;
    prev_sum = bus8.sum_out; prev_carry = bus8.carry_out;
    seen = 0; busy_n = 0; lat = 0; stable = 1; overlap = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      bus8.start_in = 1'b0;
      bus8.a_in = 8'($urandom); bus8.b_in = 8'($urandom); bus8.c_in = 1'($urandom);
      if (bus8.busy_out === 1'b1 && bus8.done_out === 1'b1) overlap = 1;
      if (bus8.busy_out === 1'b1) busy_n++;
      if (bus8.done_out === 1'b1) begin
        seen = 1; lat = i;
      end else if (bus8.sum_out !== prev_sum || bus8.carry_out !== prev_carry) begin
        stable = 0;
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL %s done_timeout: got no done want done", tag); end
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL %s done_latency: got %0d want 9", tag, lat); end
    checks++;
    if (busy_n !== 8) begin errors++; $display("FAIL %s busy_cycles: got %0d want 8", tag, busy_n); end
    checks++;
    if (overlap) begin errors++; $display("FAIL %s busy_done_overlap: got 1 want 0", tag); end
    checks++;
    if (!stable) begin errors++; $display("FAIL %s result_stable: got change before done want hold", tag); end
    checks++;
    if ({bus8.carry_out, bus8.sum_out} !== expv) begin
      errors++;
      $display("FAIL %s result: got %b/%h want %b/%h", tag, bus8.carry_out, bus8.sum_out, expv[8], expv[7:0]);
    end
    @(negedge clk);
    checks++;
    if (bus8.done_out !== 1'b0 || bus8.busy_out !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: got busy=%b done=%b want 0/0", tag, bus8.busy_out, bus8.done_out);
    end
    $display("op %s: %h + %h + %b -> %b/%h", tag, a, b, c, bus8.carry_out, bus8.sum_out);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus8.start_in = 1'b0; bus8.a_in = '0; bus8.b_in = '0; bus8.c_in = 1'b0;
    bus4.start_in = 1'b0; bus4.a_in = '0; bus4.b_in = '0; bus4.c_in = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus8.sum_out, bus8.carry_out, bus8.busy_out, bus8.done_out} !== 11'd0) begin
      errors++;
      $display("FAIL reset8: got sum=%h c=%b busy=%b done=%b want all 0",
               bus8.sum_out, bus8.carry_out, bus8.busy_out, bus8.done_out);
    end
    checks++;
    if ({bus4.sum_out, bus4.carry_out, bus4.busy_out, bus4.done_out} !== 7'd0) begin
      errors++;
      $display("FAIL reset4: got sum=%h c=%b busy=%b done=%b want all 0",
               bus4.sum_out, bus4.carry_out, bus4.busy_out, bus4.done_out);
    end
    rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_directed();
    run8(8'h0F, 8'h01, 1'b0, "T1");
    run8(8'hFF, 8'h01, 1'b0, "T2");
    run8(8'hFF, 8'hFF, 1'b1, "T3a");
    run8(8'h00, 8'h00, 1'b0, "T3b");
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++)
      run8(8'($urandom), 8'($urandom), 1'($urandom), "rand");
  endtask

  task automatic test_ignore_start();
    bit seen;
    int extra_busy, extra_done;
    @(negedge clk);
    bus8.start_in = 1'b1; bus8.a_in = 8'h12; bus8.b_in = 8'h34; bus8.c_in = 1'b0;
    seen = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (i == 1) bus8.start_in = 1'b0;
      if (i == 4) begin bus8.start_in = 1'b1; bus8.a_in = 8'hAA; bus8.b_in = 8'h55; end
      if (i == 5) bus8.start_in = 1'b0;
      if (bus8.done_out === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || bus8.sum_out !== 8'h46 || bus8.carry_out !== 1'b0) begin
      errors++;
      $display("FAIL T4_ignore: got done=%b %b/%h want 1 0/46", seen, bus8.carry_out, bus8.sum_out);
    end
    extra_busy = 0; extra_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.busy_out === 1'b1) extra_busy++;
      if (bus8.done_out === 1'b1) extra_done++;
    end
    checks++;
    if (extra_busy != 0 || extra_done != 0) begin
      errors++;
      $display("FAIL T4_no_queued_op: got busy=%0d done=%0d want 0/0", extra_busy, extra_done);
    end
    $display("op T4: 12 + 34 with mid-run restart -> %b/%h", bus8.carry_out, bus8.sum_out);
  endtask

  task automatic test_back_to_back();
    logic [7:0] a1, b1, a2, b2;
    logic       c1, c2;
    logic [8:0] e1, e2;
    bit         seen;
    int         gap;
    a1 = 8'($urandom); b1 = 8'($urandom); c1 = 1'($urandom);
    a2 = 8'($urandom); b2 = 8'($urandom); c2 = 1'($urandom);
    e1 = 9'(a1) + 9'(b1) + 9'(c1);
    e2 = 9'(a2) + 9'(b2) + 9'(c2);
    @(negedge clk);
    bus8.start_in = 1'b1; bus8.a_in = a1; bus8.b_in = b1; bus8.c_in = c1;
    seen = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (bus8.done_out === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || {bus8.carry_out, bus8.sum_out} !== e1) begin
      errors++;
      $display("FAIL b2b_first: got done=%b %b/%h want 1 %b/%h", seen, bus8.carry_out, bus8.sum_out, e1[8], e1[7:0]);
    end
    bus8.a_in = a2; bus8.b_in = b2; bus8.c_in = c2;
    seen = 0; gap = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (bus8.done_out === 1'b1) begin seen = 1; gap = i; end
    end
    bus8.start_in = 1'b0;
    checks++;
    if (gap !== 10) begin errors++; $display("FAIL b2b_period: got %0d want 10", gap); end
    checks++;
    if ({bus8.carry_out, bus8.sum_out} !== e2) begin
      errors++;
      $display("FAIL b2b_second: got %b/%h want %b/%h", bus8.carry_out, bus8.sum_out, e2[8], e2[7:0]);
    end
    $display("op b2b: %h+%h+%b then %h+%h+%b -> %b/%h", a1, b1, c1, a2, b2, c2, bus8.carry_out, bus8.sum_out);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset();
    int busy_n, done_n;
    bit moved;
    run8(8'h33, 8'h44, 1'b0, "pre_rst");
    @(negedge clk);
    bus8.start_in = 1'b1; bus8.a_in = 8'h5A; bus8.b_in = 8'hC3; bus8.c_in = 1'b1;
    repeat (3) begin
      @(negedge clk);
      bus8.start_in = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus8.sum_out, bus8.carry_out, bus8.busy_out, bus8.done_out} !== 11'd0) begin
      errors++;
      $display("FAIL T5_async_clear: got sum=%h c=%b busy=%b done=%b want all 0",
               bus8.sum_out, bus8.carry_out, bus8.busy_out, bus8.done_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    busy_n = 0; done_n = 0; moved = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus8.busy_out === 1'b1) busy_n++;
      if (bus8.done_out === 1'b1) done_n++;
      if (bus8.sum_out !== 8'h00 || bus8.carry_out !== 1'b0) moved = 1;
    end
    checks++;
    if (busy_n != 0 || done_n != 0 || moved) begin
      errors++;
      $display("FAIL T5_discarded: got busy=%0d done=%0d changed=%b want 0/0/0", busy_n, done_n, moved);
    end
    $display("op T5: reset mid-run discarded");
    run8(8'h80, 8'h80, 1'b0, "T5_after");
  endtask

  task automatic test_exhaustive4();
    int         issued, base, bad;
    logic [8:0] combo;
    logic [4:0] expv;
    bit         seen;
    issued = 0; bad = 0; base = done4_cnt;
    for (int n = 0; n < 512; n++) begin
      combo = 9'(n);
      expv = 5'(combo[3:0]) + 5'(combo[7:4]) + 5'(combo[8]);
      @(negedge clk);
      bus4.start_in = 1'b1; bus4.a_in = combo[3:0]; bus4.b_in = combo[7:4]; bus4.c_in = combo[8];
      issued++;
      seen = 0;
      for (int i = 1; i <= 20 && !seen; i++) begin
        @(negedge clk);
        bus4.start_in = 1'b0;
        if (bus4.done_out === 1'b1) seen = 1;
      end
      checks++;
      if (!seen || {bus4.carry_out, bus4.sum_out} !== expv) begin
        errors++; bad++;
        if (bad <= 10)
          $display("FAIL w4_sum %h+%h+%b: got done=%b %b/%h want 1 %b/%h", combo[3:0], combo[7:4], combo[8],
                   seen, bus4.carry_out, bus4.sum_out, expv[4], expv[3:0]);
      end
      $display("op w4: %h + %h + %b -> %b/%h", combo[3:0], combo[7:4], combo[8], bus4.carry_out, bus4.sum_out);
    end
    @(negedge clk);
    checks++;
    if (done4_cnt - base != issued) begin
      errors++;
      $display("FAIL w4_done_count: got %0d want %0d", done4_cnt - base, issued);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    test_exhaustive4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
